// File: rtl/cpu_pkg.sv
// Shared CPU package: PC width and return-stack sizing used by the fetch path.
package cpu_pkg;

  localparam int PC_WIDTH     = 10;
  localparam int RS_DEPTH_DEF = 8;
  localparam int RS_PTR_W     = $clog2(RS_DEPTH_DEF);

endpackage : cpu_pkg

// File: rtl/return_stack_if.sv
// Return-stack bus: call/return strobes and address in, stack status and top entry out.
interface return_stack_if
  import cpu_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int DEPTH = RS_DEPTH_DEF
);

  logic                     push;
  logic                     pop;
  logic [WIDTH-1:0]         din;
  logic [WIDTH-1:0]         top;
  logic                     empty;
  logic                     full;
  logic [$clog2(DEPTH):0]   count;
  logic                     err;

  modport master (
    output push, pop, din,
    input  top, empty, full, count, err
  );

  modport slave (
    input  push, pop, din,
    output top, empty, full, count, err
  );

endinterface : return_stack_if

// File: rtl/return_stack_mem.sv
// DEPTH x WIDTH register array with one synchronous write port and one combinational read port.
module return_stack_mem
  import cpu_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int DEPTH = RS_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   wa,
  input  logic [WIDTH-1:0]           wd,
  input  logic [$clog2(DEPTH)-1:0]   ra,
  output logic [WIDTH-1:0]           rd
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // storage write; contents are deliberately never reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[wa] <= wd;
    end
  end

  assign rd = mem_r[ra];

endmodule : return_stack_mem

// File: rtl/return_stack.sv
// Circular-buffer return-address stack feeding the next-PC mux.
// Optional sticky overflow/underflow flag enabled by RETURN_STACK_ERR_EN.
module return_stack
  import cpu_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int DEPTH = RS_DEPTH_DEF
) (
  input  logic           clk,
  input  logic           reset,
  return_stack_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    sp_r;
  logic [CW-1:0]    cnt_r;
  logic [PW-1:0]    sp_nxt_s;
  logic [CW-1:0]    cnt_nxt_s;
  logic             we_s;
  logic [PW-1:0]    wa_s;
  logic [PW-1:0]    ra_s;
  logic [WIDTH-1:0] rd_s;
  logic             empty_s;
  logic             full_s;

  assign empty_s = (cnt_r == CW'(0));
  assign full_s  = (cnt_r == CW'(DEPTH));
  assign ra_s    = sp_r - PW'(1);

  // next pointer/count and write-port control
  always_comb begin
    sp_nxt_s  = sp_r;
    cnt_nxt_s = cnt_r;
    we_s      = 1'b0;
    wa_s      = sp_r;
    if (bus.push && (!bus.pop || empty_s)) begin
      // plain push; when full the write lands on the oldest slot
      we_s     = 1'b1;
      wa_s     = sp_r;
      sp_nxt_s = sp_r + PW'(1);
      if (full_s) begin
        cnt_nxt_s = cnt_r;
      end else begin
        cnt_nxt_s = cnt_r + CW'(1);
      end
    end else if (bus.push && bus.pop) begin
      we_s = 1'b1;
      wa_s = sp_r - PW'(1);
    end else if (bus.pop) begin
      if (empty_s) begin
        sp_nxt_s  = sp_r;
        cnt_nxt_s = cnt_r;
      end else begin
        sp_nxt_s  = sp_r - PW'(1);
        cnt_nxt_s = cnt_r - CW'(1);
      end
    end else begin
      sp_nxt_s  = sp_r;
      cnt_nxt_s = cnt_r;
    end
  end

  // stack pointer and entry count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_r  <= '0;
      cnt_r <= '0;
    end else begin
      sp_r  <= sp_nxt_s;
      cnt_r <= cnt_nxt_s;
    end
  end

  return_stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk (clk),
    .we  (we_s),
    .wa  (wa_s),
    .wd  (bus.din),
    .ra  (ra_s),
    .rd  (rd_s)
  );

  // top is masked to zero when empty so stale memory never leaks out
  always_comb begin
    if (empty_s) begin
      bus.top = '0;
    end else begin
      bus.top = rd_s;
    end
  end

  assign bus.empty = empty_s;
  assign bus.full  = full_s;
  assign bus.count = cnt_r;

`ifdef RETURN_STACK_ERR_EN
  logic err_r;
  logic ovf_s;
  logic unf_s;

  assign ovf_s = bus.push && !bus.pop && full_s;
  assign unf_s = bus.pop && !bus.push && empty_s;

  // sticky error flag, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_r <= 1'b0;
    end else if (ovf_s || unf_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign bus.err = err_r;
`else
  assign bus.err = 1'b0;
`endif

endmodule : return_stack

// File: tb/tb_return_stack.sv
// Directed self-checking bench for return_stack (DEPTH=8, WIDTH=10).
module tb_return_stack;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

`ifdef RETURN_STACK_ERR_EN
  localparam logic [31:0] ERR_EXP = 32'd1;
`else
  localparam logic [31:0] ERR_EXP = 32'd0;
`endif

  return_stack_if bus ();

  return_stack dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_op(input logic p, input logic q, input logic [9:0] d);
    bus.push = p;
    bus.pop  = q;
    bus.din  = d;
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    reset    = 1'b1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    bus.din  = 10'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full",  32'(bus.full),  32'd0);
    check("rst_top",   32'(bus.top),   32'd0);
    check("rst_err",   32'(bus.err),   32'd0);
    reset = 1'b0;

    // three pushes
    do_op(1'b1, 1'b0, 10'h005);
    check("p1_count", 32'(bus.count), 32'd1);
    check("p1_top",   32'(bus.top),   32'h005);
    check("p1_empty", 32'(bus.empty), 32'd0);
    do_op(1'b1, 1'b0, 10'h010);
    check("p2_count", 32'(bus.count), 32'd2);
    check("p2_top",   32'(bus.top),   32'h010);
    do_op(1'b1, 1'b0, 10'h3FF);
    check("p3_count", 32'(bus.count), 32'd3);
    check("p3_top",   32'(bus.top),   32'h3FF);

    // pops down to empty, then underflow
    do_op(1'b0, 1'b1, 10'h000);
    check("q1_top", 32'(bus.top), 32'h010);
    do_op(1'b0, 1'b1, 10'h000);
    check("q2_top", 32'(bus.top), 32'h005);
    do_op(1'b0, 1'b1, 10'h000);
    check("q3_top",   32'(bus.top),   32'h000);
    check("q3_empty", 32'(bus.empty), 32'd1);
    check("q3_err",   32'(bus.err),   32'd0);
    do_op(1'b0, 1'b1, 10'h000);
    check("q4_count", 32'(bus.count), 32'd0);
    check("q4_top",   32'(bus.top),   32'h000);
    check("q4_err",   32'(bus.err),   ERR_EXP);

    // overflow: nine pushes into eight slots
    pulse_reset();
    check("rst2_err", 32'(bus.err), 32'd0);
    for (int i = 1; i <= 9; i++) begin
      do_op(1'b1, 1'b0, 10'(i));
      if (i == 7) check("ov7_full", 32'(bus.full), 32'd0);
      if (i == 8) check("ov8_full", 32'(bus.full), 32'd1);
      if (i == 8) check("ov8_err",  32'(bus.err),  32'd0);
    end
    check("ov9_top",   32'(bus.top),   32'h009);
    check("ov9_count", 32'(bus.count), 32'd8);
    check("ov9_full",  32'(bus.full),  32'd1);
    check("ov9_err",   32'(bus.err),   ERR_EXP);
    for (int i = 1; i <= 8; i++) begin
      do_op(1'b0, 1'b1, 10'h000);
      check("ovpop_top",   32'(bus.top),   (i < 8) ? 32'(9 - i) : 32'd0);
      check("ovpop_count", 32'(bus.count), 32'(8 - i));
    end
    check("ovpop_empty", 32'(bus.empty), 32'd1);

    // tail replace with two entries
    pulse_reset();
    do_op(1'b1, 1'b0, 10'h010);
    do_op(1'b1, 1'b0, 10'h020);
    do_op(1'b1, 1'b1, 10'h044);
    check("tr_count", 32'(bus.count), 32'd2);
    check("tr_top",   32'(bus.top),   32'h044);
    do_op(1'b0, 1'b1, 10'h000);
    check("tr_pop_top",   32'(bus.top),   32'h010);
    check("tr_pop_count", 32'(bus.count), 32'd1);

    // tail replace when full is not an overflow
    pulse_reset();
    for (int i = 0; i < 8; i++) do_op(1'b1, 1'b0, 10'(32'h100 + i));
    do_op(1'b1, 1'b1, 10'h055);
    check("trf_count", 32'(bus.count), 32'd8);
    check("trf_top",   32'(bus.top),   32'h055);
    check("trf_err",   32'(bus.err),   32'd0);
    do_op(1'b0, 1'b1, 10'h000);
    check("trf_pop_top", 32'(bus.top), 32'h106);

    // push and pop together on an empty stack
    pulse_reset();
    do_op(1'b1, 1'b1, 10'h0AA);
    check("pe_count", 32'(bus.count), 32'd1);
    check("pe_top",   32'(bus.top),   32'h0AA);
    check("pe_err",   32'(bus.err),   32'd0);

    // asynchronous reset between edges with push held
    pulse_reset();
    do_op(1'b1, 1'b0, 10'h001);
    do_op(1'b1, 1'b0, 10'h002);
    do_op(1'b1, 1'b0, 10'h003);
    check("ar_pre_count", 32'(bus.count), 32'd3);
    bus.push = 1'b1;
    bus.din  = 10'h077;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("ar_count", 32'(bus.count), 32'd0);
    check("ar_top",   32'(bus.top),   32'd0);
    check("ar_empty", 32'(bus.empty), 32'd1);
    check("ar_full",  32'(bus.full),  32'd0);
    check("ar_err",   32'(bus.err),   32'd0);
    @(posedge clk);
    #1;
    check("ar_hold_count", 32'(bus.count), 32'd0);
    bus.push = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    do_op(1'b1, 1'b0, 10'h123);
    check("ar_post_count", 32'(bus.count), 32'd1);
    check("ar_post_top",   32'(bus.top),   32'h123);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_return_stack

// File: doc/return_stack.md
# return_stack

Hardware return-address stack for the monocycle CPU. It sits directly upstream of the PC register, beside the PC adder. On a call instruction it saves the return address, which is the adder output PC+1. On a return instruction it presents the saved address on `top`, which drives one input of the next-PC mux4. It is a small LIFO with a circular buffer, a write-enable style interface and a registered stack pointer and count.

## Interface
Parameters:
- `WIDTH`, 10, address width; matches the PC adder width.
- `DEPTH`, 8, number of entries; must be a power of two, minimum 2.

Ports:
- `clk`  input  1  clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-high; clears pointer, count and error flag.
- `push`  input  1  save `din` (call instruction).
- `pop`  input  1  discard the top entry (return instruction).
- `din`  input  WIDTH  return address to save (PC+1).
- `top`  output  WIDTH  current top entry; combinational from the registered state.
- `empty`  output  1  count == 0.
- `full`  output  1  count == DEPTH.
- `count`  output  log2(DEPTH)+1  number of valid entries.
- `err`  output  1  sticky overflow/underflow flag (see Configuration).

## Operation
- State:
  - `sp`: log2(DEPTH) bits; next write slot.
  - `cnt`: 0..DEPTH.
  - `mem[0:DEPTH-1]`: storage; not reset and not initialised.
- `top` = `mem[sp-1]` (modulo DEPTH) when `cnt` > 0; 0 when `cnt` == 0.
- Behaviour per cycle, evaluated at the rising edge:
  - Idle (push=0, pop=0): no change.
  - Push only:
    - Writes `mem[sp] <= din`.
    - `sp <= sp+1`, wrapping modulo DEPTH.
    - `cnt <= cnt+1`, saturating at DEPTH.
  - Push only when full: the write wraps onto the oldest entry. `cnt` stays DEPTH. This is an overflow event.
  - Pop only, `cnt` > 0: `sp <= sp-1` (modulo DEPTH), `cnt <= cnt-1`. Memory is unchanged.
  - Pop only, empty: no state change. `top` stays 0. This is an underflow event.
  - Push and pop, `cnt` > 0 (tail replace):
    - Writes `mem[sp-1] <= din`.
    - `sp` and `cnt` are unchanged.
    - Not an overflow, even when full.
  - Push and pop, empty: behaves as push only. Not an underflow.
- `full` and `empty` are decoded from `cnt` only.

## Timing
- Reset state: `sp`=0, `cnt`=0, `empty`=1, `full`=0, `count`=0, `top`=0, `err`=0.
- Reset is asynchronous. Asserting it mid-operation clears the state immediately, regardless of `push`/`pop`. Memory contents are retained but unreachable.
- Latency:
  - A push is visible on `top`, `count` and `full` in the cycle after the edge that captured it.
  - A pop reveals the previous entry in the cycle after its edge.
- `top` has no combinational path from `push`, `pop` or `din`. The next-PC mux therefore sees a stable value in the same cycle the return instruction is decoded.

## Configuration
- Macro: `RETURN_STACK_ERR_EN`.
- Defined:
  - `err` is set on the edge where an overflow (push-only when full) or an underflow (pop-only when empty) occurs.
  - `err` holds until `reset`.
  - Stack behaviour is identical with or without the macro.
- Not defined: `err` is tied to 0 and no flag register is synthesised. The port list is identical in both cases.

## Structure
- Shared package `cpu_pkg`:
  - `RS_DEPTH_DEF` = 8.
  - `PC_WIDTH` = 10.
  - Derived pointer width: `$clog2(RS_DEPTH_DEF)`.
- One sub-module, `return_stack_mem`:
  - DEPTH x WIDTH register array.
  - One synchronous write port (we, wa, wd).
  - One combinational read port (ra, rd).
- Pointer/count logic, the empty-top masking and the error flag stay in `return_stack`.

## Test plan
- Reset, then push 0x005, 0x010, 0x3FF on consecutive cycles:
  - `count` = 1, 2, 3.
  - `top` = 0x005, 0x010, 0x3FF one cycle after each push.
  - `empty` deasserts after the first push.
- From that state, pop three times:
  - `top` = 0x010, 0x005, 0.
  - `empty` = 1 after the third pop.
  - A fourth pop changes nothing. `err` = 1 only with `RETURN_STACK_ERR_EN`.
- With DEPTH=8, push 0x001..0x009 (nine pushes):
  - `full` = 1 after the eighth push.
  - After the ninth, `top` = 0x009 and `count` = 8.
  - Eight pops return 0x008..0x002; 0x001 is lost.
  - `err` = 1 (with the macro).
- With `count` = 2 (0x020 on 0x010), assert push and pop together with `din` = 0x044:
  - `count` stays 2 and `top` = 0x044.
  - One pop then gives `top` = 0x010.
- Assert push and pop together on an empty stack with `din` = 0x0AA: `count` = 1, `top` = 0x0AA, `err` stays 0.
- With `count` = 3, assert `reset` asynchronously between edges with push held high:
  - Outputs go to their reset values immediately.
  - After release, the next push of 0x123 gives `count` = 1 and `top` = 0x123.
